// File: rtl/pe_mlane_if.sv
// Operand/result bundle for the multi-lane MAC element. Each packed bus carries
// LANES slices; lane k sits at [k*W +: W].
interface pe_mlane_if #(
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int LANES  = 4
);
    logic [1:0]              mode_i;
    logic                    mode_ld_i;
    logic                    in_valid_i;
    logic [LANES*MUL_BW-1:0] x_i;
    logic [LANES*MUL_BW-1:0] wc_i;
    logic [LANES*MUL_BW-1:0] var_i;
    logic [LANES*ACC_BW-1:0] mac_i;
    logic [LANES*ACC_BW-1:0] o_i;
    logic                    sat_clr_i;
    logic [LANES*MUL_BW-1:0] x_o;
    logic [LANES*MUL_BW-1:0] wc_o;
    logic [LANES*ACC_BW-1:0] o_o;
    logic                    out_valid_o;
    logic                    busy_o;
    logic [1:0]              mode_o;
    logic [LANES-1:0]        sat_o;

    modport master (
        output mode_i, mode_ld_i, in_valid_i, x_i, wc_i, var_i, mac_i, o_i, sat_clr_i,
        input  x_o, wc_o, o_o, out_valid_o, busy_o, mode_o, sat_o
    );

    modport slave (
        input  mode_i, mode_ld_i, in_valid_i, x_i, wc_i, var_i, mac_i, o_i, sat_clr_i,
        output x_o, wc_o, o_o, out_valid_o, busy_o, mode_o, sat_o
    );
endinterface

// File: rtl/pe_mlane.sv
// Multi-lane two-stage MAC element: gemm (wc*x + o_i) or uno (sat(mac)*var + wc)
// with saturating accumulation and sticky per-lane saturation flags.
module pe_mlane #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 10,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int LANES  = 4
) (
    input logic       clk,
    input logic       rst_n,
    pe_mlane_if.slave bus
);
    localparam int SAT_EXP = INT_BW + 2 * FRA_BW;
    localparam int PAD_BW  = MUL_BW - 1 - INT_BW - FRA_BW;
    localparam logic [1:0] MODE_GEMM = 2'b00;

    // Q-format window of the upstream MAC result; outside it the truncation clamps.
    localparam logic signed [ACC_BW-1:0] MAC_HI = ACC_BW'((64'sd1 <<< SAT_EXP) - 64'sd1);
    localparam logic signed [ACC_BW-1:0] MAC_LO = ~MAC_HI;
    localparam logic [MUL_BW-1:0] MACT_MAX =
        MUL_BW'((64'd1 << (INT_BW + FRA_BW)) - 64'd1) << PAD_BW;
    localparam logic [MUL_BW-1:0] MACT_MIN = {1'b1, {(MUL_BW - 1){1'b0}}};

    // Returns {clamped, mac_t}.
    function automatic logic [MUL_BW:0] mac_trunc(input logic signed [ACC_BW-1:0] m);
        logic [MUL_BW:0] r;
        if (m > MAC_HI)      r = {1'b1, MACT_MAX};
        else if (m < MAC_LO) r = {1'b1, MACT_MIN};
        else                 r = {1'b0, m[ACC_BW-1 -: MUL_BW]};
        return r;
    endfunction

    // Returns {clamped, value}; overflow shows as disagreement of the top two bits.
    function automatic logic [ACC_BW:0] clamp_acc(input logic signed [ACC_BW:0] s);
        logic [ACC_BW:0] r;
        if (s[ACC_BW] != s[ACC_BW-1]) r = {1'b1, s[ACC_BW], {(ACC_BW - 1){~s[ACC_BW]}}};
        else                          r = {1'b0, s[ACC_BW-1:0]};
        return r;
    endfunction

    logic                    s1_vld_q;
    logic [LANES*MUL_BW-1:0] s1_x_q;
    logic [LANES*MUL_BW-1:0] s1_wc_q;
    logic [LANES*MUL_BW-1:0] s1_var_q;
    logic [LANES*ACC_BW-1:0] s1_mac_q;
    logic [LANES*ACC_BW-1:0] s1_o_q;

    logic                    s2_vld_q;
    logic [LANES*ACC_BW-1:0] s2_o_q;
    logic [LANES*ACC_BW-1:0] s2_o_d;

    logic [LANES-1:0]        sat_q, sat_d, sat_hit;
    logic [1:0]              mode_q, mode_d;
    logic                    busy;
    logic                    gemm;

    assign busy = s1_vld_q | s2_vld_q;
    assign gemm = (mode_q == MODE_GEMM);

    // Stage 2 datapath: evaluated on S1 contents, registered on the next edge.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [MUL_BW-1:0]   x_l, wc_l, var_l;
        logic signed [ACC_BW-1:0]   mac_l, o_l;
        logic        [MUL_BW:0]     mt;
        logic signed [MUL_BW-1:0]   op_a, op_b;
        logic signed [2*MUL_BW-1:0] prod;
        logic signed [ACC_BW:0]     sum;
        logic        [ACC_BW:0]     cl;

        assign x_l   = s1_x_q[k*MUL_BW +: MUL_BW];
        assign wc_l  = s1_wc_q[k*MUL_BW +: MUL_BW];
        assign var_l = s1_var_q[k*MUL_BW +: MUL_BW];
        assign mac_l = s1_mac_q[k*ACC_BW +: ACC_BW];
        assign o_l   = s1_o_q[k*ACC_BW +: ACC_BW];

        assign mt   = mac_trunc(mac_l);
        assign op_a = gemm ? wc_l : signed'(mt[MUL_BW-1:0]);
        assign op_b = gemm ? x_l : var_l;
        assign prod = (2 * MUL_BW)'(op_a) * (2 * MUL_BW)'(op_b);
        assign sum  = (ACC_BW + 1)'(prod)
                    + (gemm ? (ACC_BW + 1)'(o_l) : (ACC_BW + 1)'(wc_l));
        assign cl   = clamp_acc(sum);

        assign s2_o_d[k*ACC_BW +: ACC_BW] = cl[ACC_BW-1:0];
        assign sat_hit[k] = cl[ACC_BW] | (~gemm & mt[MUL_BW]);
    end

    // A flag raised by a completing beat outranks a same-edge clear.
    always_comb begin
        sat_d = (bus.sat_clr_i ? '0 : sat_q) | (s1_vld_q ? sat_hit : '0);
        mode_d = mode_q;
        if (bus.mode_ld_i && !busy && !bus.in_valid_i) mode_d = bus.mode_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_x_q   <= '0;
            s1_wc_q  <= '0;
            s1_var_q <= '0;
            s1_mac_q <= '0;
            s1_o_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_o_q   <= '0;
            sat_q    <= '0;
            mode_q   <= MODE_GEMM;
        end else begin
            // Stage 1: operand capture
            s1_vld_q <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                s1_x_q   <= bus.x_i;
                s1_wc_q  <= bus.wc_i;
                s1_var_q <= bus.var_i;
                s1_mac_q <= bus.mac_i;
                s1_o_q   <= bus.o_i;
            end
            // Stage 2: result register
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) s2_o_q <= s2_o_d;
            sat_q  <= sat_d;
            mode_q <= mode_d;
        end
    end

    assign bus.x_o         = s1_x_q;
    assign bus.wc_o        = s1_wc_q;
    assign bus.o_o         = s2_o_q;
    assign bus.out_valid_o = s2_vld_q;
    assign bus.busy_o      = busy;
    assign bus.mode_o      = mode_q;
    assign bus.sat_o       = sat_q;
endmodule

// File: tb/tb_pe_mlane.sv
// Directed bench for pe_mlane: table of single-beat lane-0 vectors plus
// streaming, mode-load, sticky-flag and mid-flight reset sequences.
module tb_pe_mlane;
    localparam int LANES = 4;
    localparam int MW    = 16;
    localparam int AW    = 32;
    localparam int NV    = 13;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    pe_mlane_if #(.MUL_BW(MW), .ACC_BW(AW), .LANES(LANES)) bus ();

    pe_mlane #(.INT_BW(5), .FRA_BW(10), .MUL_BW(MW), .ACC_BW(AW), .LANES(LANES)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] x;
        logic [15:0] wc;
        logic [15:0] vr;
        logic [31:0] mac;
        logic [31:0] oi;
        logic [31:0] exp_o;
        logic        exp_sat;
    } vec_t;

    vec_t tbl [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.mode_ld_i  = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.sat_clr_i  = 1'b0;
        bus.x_i        = '0;
        bus.wc_i       = '0;
        bus.var_i      = '0;
        bus.mac_i      = '0;
        bus.o_i        = '0;
    endtask

    task automatic load_mode(input logic [1:0] m);
        bus.mode_i    = m;
        bus.mode_ld_i = 1'b1;
        tick();
        bus.mode_ld_i = 1'b0;
    endtask

    task automatic clear_sat();
        bus.sat_clr_i = 1'b1;
        tick();
        bus.sat_clr_i = 1'b0;
    endtask

    logic [31:0] exp_s [8][LANES];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.mode_i = 2'b00;
        idle_inputs();

        //            mode   x        wc       var      mac           o_i           expected      sat
        tbl[0]  = '{2'b00, 16'h0400, 16'h0800, 16'h1111, 32'h7FFFFFFF, 32'h00000005, 32'h00200005, 1'b0};
        tbl[1]  = '{2'b00, 16'h7FFF, 16'h7FFF, 16'h0000, 32'h00000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1};
        tbl[2]  = '{2'b00, 16'h8000, 16'h7FFF, 16'h0000, 32'h00000000, 32'h80000000, 32'h80000000, 1'b1};
        tbl[3]  = '{2'b00, 16'hFFFF, 16'h0003, 16'h2222, 32'h80000000, 32'h00000010, 32'h0000000D, 1'b0};
        tbl[4]  = '{2'b00, 16'h8000, 16'h8000, 16'h0000, 32'h00000000, 32'h00000000, 32'h40000000, 1'b0};
        tbl[5]  = '{2'b01, 16'h3333, 16'h0001, 16'h0400, 32'h7FFFFFFF, 32'h12345678, 32'h01FFFC01, 1'b1};
        tbl[6]  = '{2'b01, 16'h3333, 16'h0001, 16'h0400, 32'h00100000, 32'h12345678, 32'h00004001, 1'b0};
        tbl[7]  = '{2'b10, 16'h0000, 16'hFFFF, 16'h0002, 32'h80000000, 32'h7FFFFFFF, 32'hFFFEFFFF, 1'b1};
        tbl[8]  = '{2'b11, 16'h0000, 16'h0005, 16'h0100, 32'hFFFF0000, 32'h00000000, 32'hFFFFFF05, 1'b0};
        tbl[9]  = '{2'b01, 16'h0000, 16'h0000, 16'h0001, 32'h01FFFFFF, 32'h00000000, 32'h000001FF, 1'b0};
        tbl[10] = '{2'b01, 16'h0000, 16'h0000, 16'h0001, 32'h02000000, 32'h00000000, 32'h00007FFF, 1'b1};
        tbl[11] = '{2'b01, 16'h0000, 16'h0000, 16'h0001, 32'hFE000000, 32'h00000000, 32'hFFFFFE00, 1'b0};
        tbl[12] = '{2'b11, 16'h0000, 16'h0000, 16'h0001, 32'hFDFFFFFF, 32'h00000000, 32'hFFFF8000, 1'b1};

        tick();
        tick();
        chk("rst_o_o", bus.o_o, '0);
        chk("rst_x_o", bus.x_o, '0);
        chk("rst_wc_o", bus.wc_o, '0);
        chk("rst_valid", bus.out_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_sat", bus.sat_o, 0);
        chk("rst_mode", bus.mode_o, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            load_mode(tbl[i].mode);
            chk($sformatf("v%0d_mode", i), bus.mode_o, tbl[i].mode);
            clear_sat();
            chk($sformatf("v%0d_sat_clr", i), bus.sat_o, 0);
            bus.x_i        = {48'h0, tbl[i].x};
            bus.wc_i       = {48'h0, tbl[i].wc};
            bus.var_i      = {48'h0, tbl[i].vr};
            bus.mac_i      = {96'h0, tbl[i].mac};
            bus.o_i        = {96'h0, tbl[i].oi};
            bus.in_valid_i = 1'b1;
            tick();
            idle_inputs();
            chk($sformatf("v%0d_x_o", i), bus.x_o, {48'h0, tbl[i].x});
            chk($sformatf("v%0d_wc_o", i), bus.wc_o, {48'h0, tbl[i].wc});
            chk($sformatf("v%0d_early_valid", i), bus.out_valid_o, 0);
            chk($sformatf("v%0d_busy", i), bus.busy_o, 1);
            tick();
            chk($sformatf("v%0d_valid", i), bus.out_valid_o, 1);
            chk($sformatf("v%0d_o_o", i), bus.o_o, {96'h0, tbl[i].exp_o});
            chk($sformatf("v%0d_sat", i), bus.sat_o, {3'b000, tbl[i].exp_sat});
            tick();
            chk($sformatf("v%0d_valid_drop", i), bus.out_valid_o, 0);
            chk($sformatf("v%0d_o_hold", i), bus.o_o, {96'h0, tbl[i].exp_o});
            chk($sformatf("v%0d_x_hold", i), bus.x_o, {48'h0, tbl[i].x});
            chk($sformatf("v%0d_sat_sticky", i), bus.sat_o, {3'b000, tbl[i].exp_sat});
            chk($sformatf("v%0d_idle", i), bus.busy_o, 0);
        end

        // Set wins over a clear on the same edge.
        load_mode(2'b00);
        clear_sat();
        bus.x_i = {4{16'h7FFF}};
        bus.wc_i = {4{16'h7FFF}};
        bus.o_i = {4{32'h7FFFFFFF}};
        bus.in_valid_i = 1'b1;
        tick();
        idle_inputs();
        bus.sat_clr_i = 1'b1;
        tick();
        bus.sat_clr_i = 1'b0;
        chk("setwins_sat", bus.sat_o, 4'hF);
        chk("setwins_o", bus.o_o, {4{32'h7FFFFFFF}});
        clear_sat();
        chk("setwins_cleared", bus.sat_o, 0);

        // Eight back-to-back beats, distinct per lane.
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < LANES; k++)
                exp_s[i][k] = (k + 2) * (i + 1) + 100 * i + k;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                for (int k = 0; k < LANES; k++) begin
                    bus.x_i[k*MW +: MW]  = 16'(c + 1);
                    bus.wc_i[k*MW +: MW] = 16'(k + 2);
                    bus.o_i[k*AW +: AW]  = 32'(100 * c + k);
                end
                bus.in_valid_i = 1'b1;
            end else begin
                idle_inputs();
            end
            tick();
            if (c >= 1 && c <= 8) begin
                chk($sformatf("str%0d_valid", c - 1), bus.out_valid_o, 1);
                for (int k = 0; k < LANES; k++)
                    chk($sformatf("str%0d_l%0d", c - 1, k), bus.o_o[k*AW +: AW], exp_s[c-1][k]);
            end else begin
                chk($sformatf("str_c%0d_novalid", c), bus.out_valid_o, 0);
            end
        end
        chk("str_idle", bus.busy_o, 0);

        // Mode load coinciding with a beat is dropped; the beat runs as gemm.
        bus.x_i = {48'h0, 16'h0002};
        bus.wc_i = {48'h0, 16'h0003};
        bus.o_i = {96'h0, 32'h00000001};
        bus.mode_i = 2'b01;
        bus.mode_ld_i = 1'b1;
        bus.in_valid_i = 1'b1;
        tick();
        idle_inputs();
        chk("ldbeat_mode", bus.mode_o, 2'b00);
        bus.mode_i = 2'b10;
        bus.mode_ld_i = 1'b1;
        tick();
        bus.mode_ld_i = 1'b0;
        chk("ldbusy_mode", bus.mode_o, 2'b00);
        chk("ldbeat_valid", bus.out_valid_o, 1);
        chk("ldbeat_o", bus.o_o, {96'h0, 32'h00000007});
        tick();
        chk("ld_idle", bus.busy_o, 0);
        load_mode(2'b10);
        chk("ldretry_mode", bus.mode_o, 2'b10);

        // Reset with two beats in flight.
        load_mode(2'b00);
        bus.x_i = {4{16'h0010}};
        bus.wc_i = {4{16'h0010}};
        bus.in_valid_i = 1'b1;
        tick();
        tick();
        chk("pre_rst_valid", bus.out_valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_o", bus.o_o, '0);
        chk("mid_rst_x", bus.x_o, '0);
        chk("mid_rst_wc", bus.wc_o, '0);
        chk("mid_rst_valid", bus.out_valid_o, 0);
        chk("mid_rst_busy", bus.busy_o, 0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("post_rst%0d_valid", c), bus.out_valid_o, 0);
        end
        chk("post_rst_o", bus.o_o, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
